mc_control: RTL and testbench

Multicycle control unit for the RV32I subset core. It sits directly upstream of the ALU and the datapath registers. Each instruction is sequenced through a Moore FSM, and the block drives the multiplexer selects, the write enables and the 3-bit ALUControl code that the ALU consumes. It closes the branch decision using the ALU Zero flag.

---
 rtl/mc_control.sv | 181 ++++++++++++++++++
 tb/tb_mc_control.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multicycle control FSM for the RV32I subset core: sequences each instruction
// and drives the datapath selects, write enables and the ALU control code.
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       IllegalOp,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    state_e     state_q;
    state_e     cur_state;
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] alu_op;

    // State register; unused codes fall back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_R:         state_q <= S_EXECUTER;
                        OP_IALU:      state_q <= S_EXECUTEI;
                        OP_BEQ:       state_q <= S_BEQ;
                        OP_JAL:       state_q <= S_JAL;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_EXECUTER,
                S_EXECUTEI,
                S_JAL:      state_q <= S_ALUWB;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // While in reset the outputs present FETCH selects with every enable held low
    assign cur_state = rst ? S_FETCH : state_q;
    assign state_o   = cur_state;

    // Moore decode of the per-state controls
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (cur_state)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_IALU, OP_BEQ, OP_JAL});
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite   = !rst && (pc_update || (branch && Zero));
    assign MemWrite  = !rst && mem_write;
    assign IRWrite   = !rst && ir_write;
    assign RegWrite  = !rst && reg_write;
    assign IllegalOp = !rst && illegal;

    // ALU decode; unsupported funct3 selects the ALU marker code
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b111;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each step queues the expected output vector
// for the cycle, then pops it and compares against the DUT mid-cycle.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;
    exp_t sb_q[$];

    mc_control dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .IllegalOp(IllegalOp), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Expected vector: state-table fields plus per-step ALUControl, ImmSrc, PCWrite, IllegalOp
    function automatic logic [20:0] mk_exp(input logic [3:0] st, input logic [2:0] aluc,
                                           input logic [1:0] imm, input logic pcw,
                                           input logic ill, input logic in_rst);
        logic adr, mw, irw, rw;
        logic [1:0] rs, sa, sb;
        adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00;
        case (st)
            4'd0:  begin irw = 1'b1; rs = 2'b10; sb = 2'b10; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  adr = 1'b1;
            4'd4:  begin rs = 2'b01; rw = 1'b1; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  sa = 2'b10;
            4'd7:  begin sa = 2'b10; sb = 2'b01; end
            4'd8:  rw = 1'b1;
            4'd9:  sa = 2'b10;
            4'd10: begin sa = 2'b01; sb = 2'b10; end
            default: ;
        endcase
        if (in_rst) begin
            irw = 1'b0; mw = 1'b0; rw = 1'b0;
        end
        return {st, pcw, adr, mw, irw, rs, sa, sb, imm, rw, aluc, ill};
    endfunction

    task automatic step(input string tag, input logic [3:0] st, input logic [2:0] aluc,
                        input logic [1:0] imm, input logic pcw, input logic ill);
        exp_t e;
        logic [20:0] obs;
        e.tag = tag;
        e.v   = mk_exp(st, aluc, imm, pcw, ill, rst);
        sb_q.push_back(e);
        @(negedge clk);
        e   = sb_q.pop_front();
        obs = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, IllegalOp};
        n_total++;
        assert (obs === e.v) n_pass++;
        else $error("FAIL %s: observed %06h expected %06h", e.tag, obs, e.v);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    initial begin
        rst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        step("por0", 4'd0, 3'b000, 2'b00, 1'b0, 1'b0);
        step("por1", 4'd0, 3'b000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        // lw: 0,1,2,3,4
        set_instr(7'b0000011, 3'b010, 1'b0);
        step("lw_fetch",   4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("lw_decode",  4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("lw_memadr",  4'd2, 3'b000, 2'b00, 1'b0, 1'b0);
        step("lw_memread", 4'd3, 3'b000, 2'b00, 1'b0, 1'b0);
        step("lw_memwb",   4'd4, 3'b000, 2'b00, 1'b0, 1'b0);

        // second lw abandoned by reset held in MEMWB
        step("lw2_fetch",  4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("lw2_decode", 4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("lw2_memadr", 4'd2, 3'b000, 2'b00, 1'b0, 1'b0);
        step("lw2_memrd",  4'd3, 3'b000, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        step("rst_memwb0", 4'd0, 3'b000, 2'b00, 1'b0, 1'b0);
        step("rst_memwb1", 4'd0, 3'b000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        // sw: 0,1,2,5
        set_instr(7'b0100011, 3'b010, 1'b0);
        step("sw_fetch",   4'd0, 3'b000, 2'b01, 1'b1, 1'b0);
        step("sw_decode",  4'd1, 3'b000, 2'b01, 1'b0, 1'b0);
        step("sw_memadr",  4'd2, 3'b000, 2'b01, 1'b0, 1'b0);
        step("sw_memwr",   4'd5, 3'b000, 2'b01, 1'b0, 1'b0);

        // R-type sub then or
        set_instr(7'b0110011, 3'b000, 1'b1);
        step("sub_fetch",  4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("sub_decode", 4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("sub_exec",   4'd6, 3'b001, 2'b00, 1'b0, 1'b0);
        step("sub_aluwb",  4'd8, 3'b000, 2'b00, 1'b0, 1'b0);
        set_instr(7'b0110011, 3'b110, 1'b0);
        step("or_fetch",   4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("or_decode",  4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("or_exec",    4'd6, 3'b011, 2'b00, 1'b0, 1'b0);
        step("or_aluwb",   4'd8, 3'b000, 2'b00, 1'b0, 1'b0);

        // I-type: addi with funct7b5 set, slti, unsupported funct3 001
        set_instr(7'b0010011, 3'b000, 1'b1);
        step("addi_fetch", 4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("addi_dec",   4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("addi_exec",  4'd7, 3'b000, 2'b00, 1'b0, 1'b0);
        step("addi_aluwb", 4'd8, 3'b000, 2'b00, 1'b0, 1'b0);
        set_instr(7'b0010011, 3'b010, 1'b0);
        step("slti_fetch", 4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("slti_dec",   4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("slti_exec",  4'd7, 3'b101, 2'b00, 1'b0, 1'b0);
        step("slti_aluwb", 4'd8, 3'b000, 2'b00, 1'b0, 1'b0);
        set_instr(7'b0010011, 3'b001, 1'b0);
        step("f3x_fetch",  4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("f3x_dec",    4'd1, 3'b000, 2'b00, 1'b0, 1'b0);
        step("f3x_exec",   4'd7, 3'b111, 2'b00, 1'b0, 1'b0);
        step("f3x_aluwb",  4'd8, 3'b000, 2'b00, 1'b0, 1'b0);

        // beq taken then not taken; Zero high in DECODE must not write PC
        set_instr(7'b1100011, 3'b000, 1'b0);
        Zero = 1'b1;
        step("beqt_fetch", 4'd0, 3'b000, 2'b10, 1'b1, 1'b0);
        step("beqt_dec",   4'd1, 3'b000, 2'b10, 1'b0, 1'b0);
        step("beqt_beq",   4'd9, 3'b001, 2'b10, 1'b1, 1'b0);
        Zero = 1'b0;
        step("beqn_fetch", 4'd0, 3'b000, 2'b10, 1'b1, 1'b0);
        step("beqn_dec",   4'd1, 3'b000, 2'b10, 1'b0, 1'b0);
        step("beqn_beq",   4'd9, 3'b001, 2'b10, 1'b0, 1'b0);

        // unsupported opcode: IllegalOp pulse in DECODE only
        set_instr(7'b1110011, 3'b000, 1'b0);
        step("ill_fetch",  4'd0, 3'b000, 2'b00, 1'b1, 1'b0);
        step("ill_dec",    4'd1, 3'b000, 2'b00, 1'b0, 1'b1);

        // jal: 0,1,10,8,0 with Zero high to show it is ignored
        set_instr(7'b1101111, 3'b000, 1'b0);
        Zero = 1'b1;
        step("jal_fetch",  4'd0, 3'b000, 2'b11, 1'b1, 1'b0);
        step("jal_dec",    4'd1, 3'b000, 2'b11, 1'b0, 1'b0);
        step("jal_jal",    4'd10, 3'b000, 2'b11, 1'b1, 1'b0);
        step("jal_aluwb",  4'd8, 3'b000, 2'b11, 1'b0, 1'b0);
        Zero = 1'b0;
        step("end_fetch",  4'd0, 3'b000, 2'b11, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
